// File: rtl/reg_spill_fill.sv
// Bulk spill/fill engine: walks a wrapping register range one beat per cycle,
// streaming register contents out or writing an incoming stream into the file.
module reg_spill_fill #(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned NumRegs    = 16,
  parameter int unsigned IndexWidth = $clog2(NumRegs)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic                  cmdFill,
  input  logic [IndexWidth-1:0] cmdBase,
  input  logic [IndexWidth:0]   cmdCount,
  output logic [IndexWidth-1:0] rfReadAddr,
  input  logic [DataWidth-1:0]  rfReadData,
  output logic                  rfWriteEn,
  output logic [IndexWidth-1:0] rfWriteAddr,
  output logic [DataWidth-1:0]  rfWriteData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DataWidth-1:0]  outData,
  output logic                  outLast,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DataWidth-1:0]  inData,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntWidth = IndexWidth + 1;
  localparam logic [CntWidth:0] NumRegsW = (CntWidth+1)'(NumRegs);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPILL,
    S_FILL,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [IndexWidth-1:0] base_q, base_d;
  logic [CntWidth-1:0]   idx_q, idx_d;
  logic [CntWidth-1:0]   rem_q, rem_d;

  logic [CntWidth:0]     base_ext;
  logic [CntWidth:0]     addr_sum;
  logic [CntWidth:0]     addr_wrap;
  logic [IndexWidth-1:0] cur_addr;
  logic [IndexWidth-1:0] base_in;
  logic [CntWidth-1:0]   count_in;
  logic                  beat;

  // Base is pre-reduced below NumRegs at latch time, so base+idx never
  // reaches 2*NumRegs and a single conditional subtract performs the wrap.
  always_comb begin
    base_ext = (CntWidth+1)'(cmdBase);
    if (base_ext >= NumRegsW) begin
      base_ext = base_ext - NumRegsW;
    end
    base_in = base_ext[IndexWidth-1:0];

    if ({1'b0, cmdCount} > NumRegsW) begin
      count_in = NumRegsW[CntWidth-1:0];
    end else begin
      count_in = cmdCount;
    end

    addr_sum  = {2'b00, base_q} + {1'b0, idx_q};
    addr_wrap = addr_sum;
    if (addr_sum >= NumRegsW) begin
      addr_wrap = addr_sum - NumRegsW;
    end
    cur_addr = addr_wrap[IndexWidth-1:0];
  end

  assign beat = ((state_q == S_SPILL) && outReady) ||
                ((state_q == S_FILL) && inValid);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmdValid) begin
          base_d = base_in;
          idx_d  = '0;
          rem_d  = count_in;
          if (count_in == '0) begin
            state_d = S_DONE;
          end else if (cmdFill) begin
            state_d = S_FILL;
          end else begin
            state_d = S_SPILL;
          end
        end
      end
      S_SPILL, S_FILL: begin
        if (beat) begin
          idx_d = idx_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == CntWidth'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cmdReady    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    outValid    = 1'b0;
    outLast     = 1'b0;
    inReady     = 1'b0;
    rfWriteEn   = 1'b0;
    rfReadAddr  = cur_addr;
    rfWriteAddr = cur_addr;
    outData     = rfReadData;
    rfWriteData = inData;
    unique case (state_q)
      S_IDLE: begin
        cmdReady = 1'b1;
        busy     = 1'b0;
      end
      S_SPILL: begin
        outValid = 1'b1;
        outLast  = (rem_q == CntWidth'(1));
      end
      S_FILL: begin
        inReady   = 1'b1;
        rfWriteEn = inValid;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_spill_fill.sv
// Directed bench for reg_spill_fill: a 16-register instance backed by a
// behavioural register file, plus a 12-register instance for wrap checks.
module tb_reg_spill_fill;

  logic       clk;
  logic       rstN;

  logic       cmdValid, cmdReady, cmdFill;
  logic [3:0] cmdBase;
  logic [4:0] cmdCount;
  logic [3:0] rfReadAddr, rfWriteAddr;
  logic [7:0] rfReadData, rfWriteData;
  logic       rfWriteEn;
  logic       outValid, outReady, outLast;
  logic [7:0] outData;
  logic       inValid, inReady;
  logic [7:0] inData;
  logic       busy, done;

  logic       b_cmdValid, b_cmdReady, b_cmdFill;
  logic [3:0] b_cmdBase;
  logic [4:0] b_cmdCount;
  logic [3:0] b_rfReadAddr, b_rfWriteAddr;
  logic [7:0] b_rfReadData, b_rfWriteData;
  logic       b_rfWriteEn;
  logic       b_outValid, b_outReady, b_outLast;
  logic [7:0] b_outData;
  logic       b_inValid, b_inReady;
  logic [7:0] b_inData;
  logic       b_busy, b_done;

  logic [7:0] rf [16];
  logic       tb_we;
  logic [3:0] tb_waddr;
  logic [7:0] tb_wdata;

  int n_checks;
  int n_pass;

  localparam int RDY1  [6] = '{1, 0, 1, 1, 0, 1};
  localparam int EXP1  [6] = '{'hA3, 'hA4, 'hA4, 'hA5, 'hA6, 'hA6};
  localparam int LAST1 [6] = '{0, 0, 0, 0, 1, 1};
  localparam int VAL2  [7] = '{1, 0, 1, 0, 0, 1, 1};
  localparam int DAT2  [4] = '{'h11, 'h22, 'h33, 'h44};
  localparam int ADR2  [4] = '{14, 15, 0, 1};
  localparam int ADR12 [4] = '{10, 11, 0, 1};

  reg_spill_fill #(.DataWidth(8), .NumRegs(16)) dut (
    .clk(clk), .rstN(rstN),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdFill(cmdFill),
    .cmdBase(cmdBase), .cmdCount(cmdCount),
    .rfReadAddr(rfReadAddr), .rfReadData(rfReadData),
    .rfWriteEn(rfWriteEn), .rfWriteAddr(rfWriteAddr), .rfWriteData(rfWriteData),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outLast(outLast),
    .inValid(inValid), .inReady(inReady), .inData(inData),
    .busy(busy), .done(done)
  );

  reg_spill_fill #(.DataWidth(8), .NumRegs(12)) dut12 (
    .clk(clk), .rstN(rstN),
    .cmdValid(b_cmdValid), .cmdReady(b_cmdReady), .cmdFill(b_cmdFill),
    .cmdBase(b_cmdBase), .cmdCount(b_cmdCount),
    .rfReadAddr(b_rfReadAddr), .rfReadData(b_rfReadData),
    .rfWriteEn(b_rfWriteEn), .rfWriteAddr(b_rfWriteAddr), .rfWriteData(b_rfWriteData),
    .outValid(b_outValid), .outReady(b_outReady), .outData(b_outData), .outLast(b_outLast),
    .inValid(b_inValid), .inReady(b_inReady), .inData(b_inData),
    .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (tb_we) begin
      rf[tb_waddr] <= tb_wdata;
    end else if (rfWriteEn) begin
      rf[rfWriteAddr] <= rfWriteData;
    end
  end
  assign rfReadData   = rf[rfReadAddr];
  assign b_rfReadData = {4'h5, b_rfReadAddr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic fill, input logic [3:0] base, input logic [4:0] count);
    cmdValid = 1'b1;
    cmdFill  = fill;
    cmdBase  = base;
    cmdCount = count;
    step();
    cmdValid = 1'b0;
  endtask

  // Register contents after preload, the first spill and the wrapping fill.
  function automatic logic [7:0] model_val(input int a);
    case (a)
      0:          model_val = 8'h33;
      1:          model_val = 8'h44;
      14:         model_val = 8'h11;
      15:         model_val = 8'h22;
      3, 4, 5, 6: model_val = 8'(32'hA0 + a);
      default:    model_val = 8'(32'h80 + a);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstN = 1'b0;
    cmdValid = 1'b0; cmdFill = 1'b0; cmdBase = '0; cmdCount = '0;
    outReady = 1'b0; inValid = 1'b0; inData = '0;
    b_cmdValid = 1'b0; b_cmdFill = 1'b0; b_cmdBase = '0; b_cmdCount = '0;
    b_outReady = 1'b0; b_inValid = 1'b0; b_inData = '0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;

    step();
    step();
    inValid = 1'b1;
    #1;
    check("rst_cmdReady", 32'(cmdReady), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_outValid", 32'(outValid), 32'd0);
    check("rst_outLast", 32'(outLast), 32'd0);
    check("rst_inReady", 32'(inReady), 32'd0);
    check("rst_rfWriteEn", 32'(rfWriteEn), 32'd0);
    check("rst_rfReadAddr", 32'(rfReadAddr), 32'd0);
    check("rst_rfWriteAddr", 32'(rfWriteAddr), 32'd0);
    check("rst_b_cmdReady", 32'(b_cmdReady), 32'd1);
    inValid = 1'b0;
    rstN = 1'b1;

    for (int i = 0; i < 16; i++) begin
      tb_we = 1'b1; tb_waddr = 4'(i); tb_wdata = 8'(32'h80 + i);
      step();
    end
    for (int i = 3; i <= 6; i++) begin
      tb_we = 1'b1; tb_waddr = 4'(i); tb_wdata = 8'(32'hA0 + i);
      step();
    end
    tb_we = 1'b0;

    // Spill with stalls
    issue_cmd(1'b0, 4'd3, 5'd4);
    for (int i = 0; i < 6; i++) begin
      outReady = (RDY1[i] != 0);
      #1;
      check("spill_valid", 32'(outValid), 32'd1);
      check("spill_data", 32'(outData), 32'(EXP1[i]));
      check("spill_last", 32'(outLast), 32'(LAST1[i]));
      check("spill_wen", 32'(rfWriteEn), 32'd0);
      step();
    end
    outReady = 1'b0;
    check("spill_done", 32'(done), 32'd1);
    check("spill_done_valid", 32'(outValid), 32'd0);
    check("spill_done_cmdReady", 32'(cmdReady), 32'd0);
    step();
    check("spill_idle_done", 32'(done), 32'd0);
    check("spill_idle_cmdReady", 32'(cmdReady), 32'd1);

    // Fill with gaps across the wrap point
    issue_cmd(1'b1, 4'd14, 5'd4);
    begin
      int k;
      k = 0;
      for (int i = 0; i < 7; i++) begin
        inValid = (VAL2[i] != 0);
        inData  = (VAL2[i] != 0) ? 8'(DAT2[k]) : 8'hEE;
        #1;
        check("fill_inReady", 32'(inReady), 32'd1);
        check("fill_outValid", 32'(outValid), 32'd0);
        check("fill_wen", 32'(rfWriteEn), 32'(VAL2[i]));
        if (VAL2[i] != 0) begin
          check("fill_waddr", 32'(rfWriteAddr), 32'(ADR2[k]));
          check("fill_wdata", 32'(rfWriteData), 32'(DAT2[k]));
          k++;
        end
        step();
      end
    end
    inValid = 1'b0;
    check("fill_done", 32'(done), 32'd1);
    check("fill_done_inReady", 32'(inReady), 32'd0);
    step();
    issue_cmd(1'b0, 4'd14, 5'd4);
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("respill_data", 32'(outData), 32'(DAT2[i]));
      check("respill_last", 32'(outLast), 32'(i == 3));
      step();
    end
    outReady = 1'b0;
    check("respill_done", 32'(done), 32'd1);
    step();

    // Count 0: immediate done, no port activity
    inValid = 1'b1;
    issue_cmd(1'b1, 4'd7, 5'd0);
    check("cnt0_done", 32'(done), 32'd1);
    check("cnt0_busy", 32'(busy), 32'd1);
    check("cnt0_wen", 32'(rfWriteEn), 32'd0);
    check("cnt0_inReady", 32'(inReady), 32'd0);
    check("cnt0_outValid", 32'(outValid), 32'd0);
    step();
    check("cnt0_idle_done", 32'(done), 32'd0);
    check("cnt0_idle_cmdReady", 32'(cmdReady), 32'd1);
    check("cnt0_idle_wen", 32'(rfWriteEn), 32'd0);
    inValid = 1'b0;

    // Oversize count clamps to NumRegs
    issue_cmd(1'b0, 4'd5, 5'd20);
    outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("big_valid", 32'(outValid), 32'd1);
      check("big_data", 32'(outData), 32'(model_val((5 + i) % 16)));
      check("big_last", 32'(outLast), 32'(i == 15));
      step();
    end
    outReady = 1'b0;
    check("big_done", 32'(done), 32'd1);
    check("big_done_valid", 32'(outValid), 32'd0);
    step();

    // Reset after two of five fill beats
    issue_cmd(1'b1, 4'd8, 5'd5);
    inValid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      inData = 8'(32'h51 + i);
      #1;
      check("rstfill_wen", 32'(rfWriteEn), 32'd1);
      check("rstfill_waddr", 32'(rfWriteAddr), 32'(8 + i));
      step();
    end
    rstN = 1'b0;
    inValid = 1'b0;
    step();
    inValid = 1'b1;
    inData = 8'h77;
    #1;
    check("rstfill_cmdReady", 32'(cmdReady), 32'd1);
    check("rstfill_busy", 32'(busy), 32'd0);
    check("rstfill_inReady", 32'(inReady), 32'd0);
    check("rstfill_post_wen", 32'(rfWriteEn), 32'd0);
    check("rstfill_waddr0", 32'(rfWriteAddr), 32'd0);
    rstN = 1'b1;
    step();
    check("rstfill_idle_wen", 32'(rfWriteEn), 32'd0);
    step();
    inValid = 1'b0;
    check("rstfill_r8", 32'(rf[8]), 32'h51);
    check("rstfill_r9", 32'(rf[9]), 32'h52);
    check("rstfill_r10", 32'(rf[10]), 32'h8A);
    check("rstfill_r11", 32'(rf[11]), 32'h8B);
    check("rstfill_r12", 32'(rf[12]), 32'h8C);

    // cmdValid held through busy is taken only after DONE
    cmdValid = 1'b1; cmdFill = 1'b0; cmdBase = 4'd0; cmdCount = 5'd2;
    step();
    outReady = 1'b1;
    #1;
    check("b2b_w0", 32'(outData), 32'h33);
    check("b2b_busy_cmdReady", 32'(cmdReady), 32'd0);
    step();
    check("b2b_w1", 32'(outData), 32'h44);
    check("b2b_w1_last", 32'(outLast), 32'd1);
    step();
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_done_cmdReady", 32'(cmdReady), 32'd0);
    step();
    check("b2b_idle_cmdReady", 32'(cmdReady), 32'd1);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    step();
    cmdValid = 1'b0;
    #1;
    check("b2b2_valid", 32'(outValid), 32'd1);
    check("b2b2_w0", 32'(outData), 32'h33);
    step();
    check("b2b2_w1", 32'(outData), 32'h44);
    step();
    check("b2b2_done", 32'(done), 32'd1);
    step();
    outReady = 1'b0;

    // cmdValid pulsed while busy is dropped
    issue_cmd(1'b0, 4'd0, 5'd3);
    cmdValid = 1'b1; cmdFill = 1'b1; cmdBase = 4'd2; cmdCount = 5'd1;
    #1;
    check("drop_stall_valid", 32'(outValid), 32'd1);
    check("drop_stall_data", 32'(outData), 32'h33);
    step();
    cmdValid = 1'b0;
    outReady = 1'b1;
    #1;
    check("drop_stall2_valid", 32'(outValid), 32'd1);
    check("drop_w0", 32'(outData), 32'h33);
    step();
    check("drop_w1", 32'(outData), 32'h44);
    step();
    check("drop_w2", 32'(outData), 32'h82);
    check("drop_w2_last", 32'(outLast), 32'd1);
    step();
    outReady = 1'b0;
    check("drop_done", 32'(done), 32'd1);
    step();
    inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("drop_idle_busy", 32'(busy), 32'd0);
      check("drop_idle_wen", 32'(rfWriteEn), 32'd0);
      step();
    end
    inValid = 1'b0;

    // Non-power-of-two wrap on the 12-register instance
    b_cmdValid = 1'b1; b_cmdFill = 1'b0; b_cmdBase = 4'd10; b_cmdCount = 5'd4;
    b_outReady = 1'b1;
    step();
    b_cmdValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("n12_valid", 32'(b_outValid), 32'd1);
      check("n12_addr", 32'(b_rfReadAddr), 32'(ADR12[i]));
      check("n12_data", 32'(b_outData), 32'h50 + 32'(ADR12[i]));
      check("n12_last", 32'(b_outLast), 32'(i == 3));
      step();
    end
    b_outReady = 1'b0;
    check("n12_done", 32'(b_done), 32'd1);
    step();
    check("n12_idle", 32'(b_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_spill_fill.md
# reg_spill_fill

Sequenced bulk-transfer engine for the register file. On a command it either spills a contiguous, wrapping range of registers out as a valid/ready word stream, or fills a range from an incoming valid/ready stream. It sits between the register file's read and write ports and a memory or debug path. It drives those ports one register per accepted beat and signals completion with a one-cycle pulse.

## Interface
- `DataWidth`, 8, register and stream word width
- `NumRegs`, 16, number of registers (any value ≥ 2)
- `IndexWidth`, `$clog2(NumRegs)`, register index width
- `clk`  in  1  clock; all state updates on rising edge
- `rstN`  in  1  reset, synchronous, active-low
- `cmdValid`  in  1  command offered
- `cmdReady`  out  1  engine idle and able to accept a command
- `cmdFill`  in  1  1 = fill (stream into registers), 0 = spill (registers to stream)
- `cmdBase`  in  IndexWidth  first register index
- `cmdCount`  in  IndexWidth+1  number of registers to transfer
- `rfReadAddr`  out  IndexWidth  register-file read address
- `rfReadData`  in  DataWidth  register-file read data, combinational from `rfReadAddr`
- `rfWriteEn`  out  1  register-file write enable
- `rfWriteAddr`  out  IndexWidth  register-file write address
- `rfWriteData`  out  DataWidth  register-file write data
- `outValid`  out  1  spill word valid
- `outReady`  in  1  spill sink ready
- `outData`  out  DataWidth  spill word
- `outLast`  out  1  marks the final spill word
- `inValid`  in  1  fill word valid
- `inReady`  out  1  engine ready for a fill word
- `inData`  in  DataWidth  fill word
- `busy`  out  1  transfer in progress (state ≠ IDLE)
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SPILL, FILL, DONE.
- **IDLE**
  - `cmdReady` = 1.
  - On `cmdValid`, latch `base`, `cmdFill` and `remaining` = min(`cmdCount`, `NumRegs`). Set `idx` = 0.
  - If `remaining` = 0, go to DONE. Otherwise go to FILL if `cmdFill`, else SPILL.
- **Current address**: `curAddr` = (`base` + `idx`) mod `NumRegs`.
  - The wrap is explicit, so it is correct for `NumRegs` that are not powers of two.
  - Example: `NumRegs` = 16, base 14, count 4 → addresses 14, 15, 0, 1.
- **SPILL**
  - `outValid` = 1, `rfReadAddr` = `curAddr`, `outData` = `rfReadData`.
  - `outLast` = 1 when `remaining` = 1.
  - On `outValid && outReady`: `idx`++ and `remaining`--. If this was the last word, go to DONE.
  - While stalled (`outReady` = 0), `rfReadAddr` is held, so `outData` stays stable as long as the register file is not written.
  - `rfWriteEn` = 0 throughout.
- **FILL**
  - `inReady` = 1, `rfWriteAddr` = `curAddr`, `rfWriteData` = `inData`.
  - `rfWriteEn` = `inValid && inReady`, combinational.
  - On each beat: `idx`++ and `remaining`--. After the last beat, go to DONE.
  - `outValid` = 0 throughout.
- **DONE**: `done` = 1 for exactly one cycle, then go to IDLE. `cmdReady` = 0 in DONE.
- **Outside the active state**: `inReady`, `outValid`, `outLast` and `rfWriteEn` are all 0.
- **Reset**: `rstN` low at any clock edge, including mid-transfer, forces IDLE and clears `idx`, `remaining` and `base`.
  - No `rfWriteEn` is asserted in the cycle after reset.
  - The partially spilled stream or partially filled range is abandoned.
- **Reset values**:
  - `cmdReady` = 1.
  - `busy`, `done`, `outValid`, `outLast`, `inReady`, `rfWriteEn` = 0.
  - `rfReadAddr`, `rfWriteAddr` = 0.
  - `rfWriteData`, `outData` follow their combinational sources.

## Timing
- Command accepted at edge N → SPILL or FILL is active in cycle N+1.
  - In SPILL, the first word is valid in cycle N+1.
  - In FILL, the first beat is accepted in cycle N+1.
- Throughput: one word per cycle when the partner holds valid/ready high.
- A count-k transfer with no stalls occupies k cycles active plus 1 DONE cycle. `cmdReady` returns in cycle N+k+2.
- Count 0: `done` pulses in cycle N+1, and there is no port activity.
- Fill writes take effect at the edge that ends the beat cycle. A spill started the cycle after `done` observes all filled values.
- `cmdValid` during busy is ignored, with no side effect.

## Test plan
- **Spill with stall**: preload regs 3..6 = 0xA3..0xA6, spill base 3, count 4, `outReady` toggling 1,0,1,1,0,1.
  - Expect stream A3, A4, A5, A6, each word held stable through its stall cycles.
  - Expect `outLast` only on A6 and `done` one cycle after the A6 beat.
- **Fill with gaps**: fill base 14, count 4, data 0x11, 0x22, 0x33, 0x44, with `inValid` gaps.
  - Expect writes to 14, 15, 0, 1 only on valid beats, then `done`.
  - A follow-up spill of the same range returns 11, 22, 33, 44.
- **Count 0 and oversize count**:
  - Count 0 → `done` in cycle N+1, no writes, no stream.
  - Count 20 with `NumRegs` = 16 → exactly 16 words, with `outLast` on the 16th.
- **Reset mid-fill**: drop `rstN` after 2 of 5 beats.
  - Expect no further writes, registers base+2..base+4 unchanged, and the engine idle with `cmdReady` = 1.
- **Back-to-back commands**:
  - A new `cmdValid` held through busy is accepted only in the cycle after DONE.
  - A `cmdValid` asserted and then dropped while busy is never executed.
- **Non-power-of-two `NumRegs` = 12**: spill base 10, count 4 → addresses 10, 11, 0, 1.
